// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel-stream datapath: FSM states, AXI-Stream channel
// byte positions and the window-geometry helpers.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int R_MSB = 31;
    localparam int G_MSB = 23;
    localparam int B_MSB = 15;

    function automatic int valid_rows(input int input_height, input int block_size);
        return input_height - block_size + 1;
    endfunction

    function automatic int out_cols(input int image_width, input int block_size);
        return image_width - block_size + 1;
    endfunction

    // Width that can hold every value 0..terminal, never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal > 0) ? $clog2(terminal + 1) : 1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream holding register: a load sets tvalid and captures data/last,
// an accept without a load clears tvalid; data and last only change on a load.
module axis_out_reg #(
    parameter int TDATA_W = 32
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               load,
    input  logic [TDATA_W-1:0] load_data,
    input  logic               load_last,
    input  logic               tready,
    output logic               tvalid,
    output logic [TDATA_W-1:0] tdata,
    output logic               tlast
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            // A load on the accepting edge replaces the beat without a bubble.
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/output_buffer.sv
// AXI-Stream master end of the convolution datapath: selects windowed result samples,
// packs them as {R,G,B,8'h00} and flags the last beat of each frame.
// Optional sticky protocol checker enabled by OUTPUT_BUFFER_PROTOCOL_CHECK_EN.
module output_buffer
    import pixel_stream_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int BLOCK_SIZE         = 3,
    parameter int INPUT_HEIGHT       = 480,
    parameter int IMAGE_WIDTH        = 640,
    parameter int LATENCY            = 2
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [DATA_WIDTH-1:0]           result_R,
    input  logic [DATA_WIDTH-1:0]           result_G,
    input  logic [DATA_WIDTH-1:0]           result_B,
    input  logic                            data_flowing,
    input  logic                            is_full_columns_first_input,
    output logic                            output_has_back_pressure,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                            m_axis_tlast,
    output logic                            protocol_error
);

    localparam int VALID_ROWS = valid_rows(INPUT_HEIGHT, BLOCK_SIZE);
    localparam int OUT_COLS   = out_cols(IMAGE_WIDTH, BLOCK_SIZE);
    localparam int DLY_W      = cnt_width(LATENCY - 1);
    localparam int ROW_W      = cnt_width(VALID_ROWS - 1);
    localparam int COL_W      = cnt_width(OUT_COLS - 1);

    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(LATENCY - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(VALID_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);

    logic flow;
    logic sync;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    logic                          vld_p0;
    logic                          last_p0;
    logic [C_AXIS_TDATA_WIDTH-1:0] data_p0;

    assign flow = data_flowing;
    assign sync = is_full_columns_first_input;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            dly_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        row_d   = row_q;
        col_d   = col_q;
        vld_p0  = 1'b0;
        last_p0 = 1'b0;
        case (state_q)
            IDLE: begin
                if (flow && sync) begin
                    state_d = DELAY;
                    dly_d   = DLY_INIT;
                end
            end
            DELAY: begin
                if (flow) begin
                    if (dly_q == '0) begin
                        state_d = EMIT;
                        row_d   = '0;
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end
            end
            EMIT: begin
                if (flow) begin
                    vld_p0 = 1'b1;
                    if (row_q == LAST_ROW) begin
                        state_d = IDLE;
                        row_d   = '0;
                        last_p0 = (col_q == LAST_COL);
                        col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        data_p0 = '0;
        data_p0[R_MSB -: DATA_WIDTH] = result_R;
        data_p0[G_MSB -: DATA_WIDTH] = result_G;
        data_p0[B_MSB -: DATA_WIDTH] = result_B;
    end

    // ---- stage p0 -> p1: captured sample enters the AXI-Stream output register
    axis_out_reg #(
        .TDATA_W (C_AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (vld_p0),
        .load_data (data_p0),
        .load_last (last_p0),
        .tready    (m_axis_tready),
        .tvalid    (m_axis_tvalid),
        .tdata     (m_axis_tdata),
        .tlast     (m_axis_tlast)
    );

    assign output_has_back_pressure = m_axis_tvalid && !m_axis_tready;
    assign m_axis_tstrb             = '1;

`ifdef OUTPUT_BUFFER_PROTOCOL_CHECK_EN
    logic perr_q;

    // Sticky: overwriting an unaccepted beat, or a column sync while a column is in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perr_q <= 1'b0;
        end else if ((vld_p0 && m_axis_tvalid && !m_axis_tready) ||
                     (flow && sync && (state_q != IDLE))) begin
            perr_q <= 1'b1;
        end
    end

    assign protocol_error = perr_q;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
AXI-Stream master end of the convolution datapath. It samples the processing block's per-pixel R/G/B results on every data-flow cycle, keeps only the samples that correspond to valid (fully windowed) output pixels, and packs them into 32-bit AXI-Stream beats with a frame-level tlast. It also generates the back-pressure signal that stalls the input buffer and the processing pipeline.

Parameters:
DATA_WIDTH, 8, bits per colour channel
C_AXIS_TDATA_WIDTH, 32, AXI-Stream data width; must be 32
BLOCK_SIZE, 3, kernel window size
INPUT_HEIGHT, 480, input rows per column
IMAGE_WIDTH, 640, input columns per frame
LATENCY, 2, data-flow cycles from sync to first valid result; must be ≥1
Derived: VALID_ROWS = INPUT_HEIGHT-BLOCK_SIZE+1; OUT_COLS = IMAGE_WIDTH-BLOCK_SIZE+1

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
result_R  in  DATA_WIDTH  processing-block red result
result_G  in  DATA_WIDTH  green result
result_B  in  DATA_WIDTH  blue result
data_flowing  in  1  pipeline advanced this cycle
is_full_columns_first_input  in  1  column sync: full window, first row entering
output_has_back_pressure  out  1  m_axis_tvalid && !m_axis_tready (combinational)
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  {R,G,B,8'h00}
m_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  constant all-ones
m_axis_tlast  out  1  last beat of frame
protocol_error  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset: asynchronous on aresetn low. Clears state to IDLE, all counters to 0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, protocol_error=0. Reset mid-frame drops any held beat.
- "flow" = data_flowing. All counters advance only on flow cycles.
- FSM:
  - IDLE: on flow && sync, go to DELAY with delay counter = LATENCY-1.
  - DELAY: on flow, decrement the counter. On flow with counter==0, go to EMIT with row counter = 0.
  - EMIT: on each flow, capture the result and increment the row counter. After the capture at row VALID_ROWS-1, go to IDLE and increment the column counter.
  - A sync outside IDLE is ignored, apart from the error flag.
- Capture: result is loaded into the output register. m_axis_tdata[31:24]=R, [23:16]=G, [15:8]=B, [7:0]=0. m_axis_tvalid is set on the next edge, so there is 1-cycle latency from the capture edge.
- m_axis_tlast=1 on the beat captured at row VALID_ROWS-1 of column OUT_COLS-1. The column counter then wraps to 0.
- Handshake:
  - Single-entry output register. tvalid holds until tvalid&&tready.
  - tdata and tlast stay stable while tvalid && !tready.
  - No capture can occur under back pressure, because data_flowing is low then.
  - Accept and capture on the same edge: the new beat is loaded and tvalid stays 1, with no bubble.
  - Accept without capture: tvalid→0.
- Counter widths: $clog2 of (terminal value + 1). No arithmetic overflow is possible.

Optional Feature:
Macro OUTPUT_BUFFER_PROTOCOL_CHECK_EN.
- Defined: protocol_error sets and stays set until reset when either of these occurs:
  - a capture occurs while tvalid && !tready;
  - flow && sync arrives in DELAY or EMIT.
- Undefined: protocol_error is tied to 0 and the checking logic is not compiled. The port remains in both cases.

Decomposition:
- Shared package (pixel_stream_pkg) holds:
  - FSM state enum {IDLE, DELAY, EMIT};
  - channel byte positions R_MSB=31, G_MSB=23, B_MSB=15;
  - helper functions for VALID_ROWS and OUT_COLS.
- One sub-module: axis_out_reg, the single-entry tvalid/tdata/tlast holding register with load/accept logic. The FSM and counters stay in output_buffer.

Test Plan:
Use INPUT_HEIGHT=6, BLOCK_SIZE=3, IMAGE_WIDTH=5, LATENCY=2, so VALID_ROWS=4 and OUT_COLS=3. tready=1 unless stated.
1. Single column: sync+flow, then 6 flows with results 0x10..0x15 on R. → 4 beats, tdata=0x12000000..0x15000000, tlast=0.
2. Frame: 3 sync'd columns. → 12 beats; tlast=1 only on beat 12; the next frame's first beat has tlast=0.
3. Back pressure: hold tready=0 with a beat pending. → output_has_back_pressure=1 and tdata stable for 5 cycles; with TB-gated data_flowing=0, no beat is lost and order is preserved.
4. Back-to-back: tready=1 with consecutive flows in EMIT. → tvalid stays 1 continuously, one beat per cycle, no bubble.
5. Gapped flow: data_flowing toggling 1/0 during DELAY/EMIT. → the same 4 beats as scenario 1; non-flow cycles are ignored.
6. Reset: assert aresetn=0 mid-EMIT with tvalid=1. → tvalid, tlast and protocol_error drop immediately; after release, a sync restarts at row 0, col 0. With macro defined, a sync during EMIT sets protocol_error=1.
